calc_input_ctrl: RTL

CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

---
 rtl/calc_input_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl: calculator key-entry controller (operand accumulate, operator, equals, clear).
// Define CALC_KEY_EDGE_EN to synchronize and edge-detect level keys; otherwise keys are single-cycle strobes.
module calc_input_ctrl #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_digit,
  input  logic [3:0]      digit,
  input  logic            key_op,
  input  logic [1:0]      op_code,
  input  logic            key_eq,
  input  logic            key_clr,
  output logic [BITS-1:0] d,
  output logic            load_a,
  output logic            load_b,
  output logic            load_op,
  output logic [1:0]      op,
  output logic            go,
  output logic            clr_o,
  output logic [BITS-1:0] disp,
  output logic            ovf,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_RES = 2'd2} state_t;
  state_t          r_state, w_nstate;
  logic [BITS-1:0] r_acc, w_nacc, r_d, w_nd;
  logic [1:0]      r_op, w_nop;
  logic            r_ovf, w_novf;
  logic            r_la, r_lb, r_lo, r_go, r_clr;
  logic            w_nla, w_nlb, w_nlo, w_ngo, w_nclr;
  logic            w_kd, w_ko, w_ke, w_kc;
  logic [BITS+3:0] w_mul;
  logic            w_big, w_dig_ok;
`ifdef CALC_KEY_EDGE_EN
  logic [3:0] r_s1, r_s2, r_s3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= {key_clr, key_eq, key_op, key_digit};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  assign {w_kc, w_ke, w_ko, w_kd} = r_s2 & ~r_s3;
`else
  assign {w_kc, w_ke, w_ko, w_kd} = {key_clr, key_eq, key_op, key_digit};
`endif
  // Wide product so overflow is detected instead of wrapping
  assign w_mul    = {4'b0, r_acc} * (BITS+4)'(10) + {{BITS{1'b0}}, digit};
  assign w_big    = |w_mul[BITS+3:BITS];
  assign w_dig_ok = w_kd && (digit <= 4'd9);
  always_comb begin
    w_nstate = r_state;
    w_nacc   = r_acc;
    w_nd     = r_d;
    w_nop    = r_op;
    w_novf   = r_ovf;
    w_nla    = 1'b0;
    w_nlb    = 1'b0;
    w_nlo    = 1'b0;
    w_ngo    = 1'b0;
    w_nclr   = 1'b0;
    if (w_kc) begin
      w_nacc   = '0;
      w_nd     = '0;
      w_nop    = '0;
      w_novf   = 1'b0;
      w_nclr   = 1'b1;
      w_nstate = S_A;
    end else begin
      case (r_state)
        S_A:
          if (!w_ke && w_ko) begin
            w_nd     = r_acc;
            w_nla    = 1'b1;
            w_nop    = op_code;
            w_nlo    = 1'b1;
            w_nacc   = '0;
            w_novf   = 1'b0;
            w_nstate = S_B;
          end else if (!w_ke && w_dig_ok) begin
            w_nacc = w_big ? r_acc : w_mul[BITS-1:0];
            w_novf = r_ovf | w_big;
          end
        S_B:
          if (w_ke) begin
            w_nd     = r_acc;
            w_nlb    = 1'b1;
            w_ngo    = 1'b1;
            w_nacc   = '0;
            w_nstate = S_RES;
          end else if (w_ko) begin
            w_nop = op_code;
            w_nlo = 1'b1;
          end else if (w_dig_ok) begin
            w_nacc = w_big ? r_acc : w_mul[BITS-1:0];
            w_novf = r_ovf | w_big;
          end
        S_RES:
          if (!w_ke && w_ko) begin
            w_nop    = op_code;
            w_nlo    = 1'b1;
            w_nstate = S_B;
          end else if (!w_ke && w_dig_ok) begin
            w_nacc   = {{(BITS-4){1'b0}}, digit};
            w_novf   = 1'b0;
            w_nstate = S_A;
          end
        default: w_nstate = S_A;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_A;
      r_acc   <= '0;
      r_d     <= '0;
      r_op    <= '0;
      r_ovf   <= 1'b0;
      r_la    <= 1'b0;
      r_lb    <= 1'b0;
      r_lo    <= 1'b0;
      r_go    <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_acc   <= w_nacc;
      r_d     <= w_nd;
      r_op    <= w_nop;
      r_ovf   <= w_novf;
      r_la    <= w_nla;
      r_lb    <= w_nlb;
      r_lo    <= w_nlo;
      r_go    <= w_ngo;
      r_clr   <= w_nclr;
    end
  assign d       = r_d;
  assign load_a  = r_la;
  assign load_b  = r_lb;
  assign load_op = r_lo;
  assign op      = r_op;
  assign go      = r_go;
  assign clr_o   = r_clr;
  assign disp    = r_acc;
  assign ovf     = r_ovf;
  assign state   = r_state;
endmodule
